// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo constants, CDB and operand types
package tomasulo_pkg;

    localparam int NUM_REGS  = 8;
    localparam int DATA_W    = 16;
    localparam int TAG_W     = 2;
    localparam int REG_IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W     = REG_IDX_W + 1;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    // Either a usable value (ready) or the tag of the RS that will produce it.
    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] value;
        logic [TAG_W-1:0]  tag;
    } operand_t;

    function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_REGS-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cdb_src_lookup.sv
// rtl/cdb_src_lookup.sv - one source-operand lookup port with same-cycle CDB bypass
module cdb_src_lookup
    import tomasulo_pkg::*;
(
    input  logic [REG_IDX_W-1:0]             idx_i,
    input  logic [NUM_REGS-1:0]              busy_i,
    input  logic [NUM_REGS-1:0][TAG_W-1:0]   qi_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
    input  cdb_t                             cdb_i,
    output operand_t                         operand_o
);

    logic              sel_busy;
    logic [TAG_W-1:0]  sel_qi;
    logic [DATA_W-1:0] sel_reg;

    assign sel_busy = busy_i[idx_i];
    assign sel_qi   = qi_i[idx_i];
    assign sel_reg  = regs_i[idx_i];

    always_comb begin
        operand_o = '0;
        if (!sel_busy) begin
            operand_o.ready = 1'b1;
            operand_o.value = sel_reg;
        end else if (cdb_i.valid && (cdb_i.tag == sel_qi)) begin
            // Producer is broadcasting right now: forward instead of waiting a cycle.
            operand_o.ready = 1'b1;
            operand_o.value = cdb_i.data;
        end else begin
            operand_o.tag = sel_qi;
        end
    end

endmodule

// File: rtl/cdb_register_writeback.sv
// rtl/cdb_register_writeback.sv - register file and Qi table updated by issue and CDB writeback
module cdb_register_writeback
    import tomasulo_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_IDX_W-1:0]  issue_rd,
    input  logic [TAG_W-1:0]      issue_tag,
    input  logic [REG_IDX_W-1:0]  src_a_idx,
    input  logic [REG_IDX_W-1:0]  src_b_idx,
    output logic                  src_a_ready,
    output logic                  src_b_ready,
    output logic [DATA_W-1:0]     src_a_value,
    output logic [DATA_W-1:0]     src_b_value,
    output logic [TAG_W-1:0]      src_a_tag,
    output logic [TAG_W-1:0]      src_b_tag,
    input  logic                  cdb_valid,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic [DATA_W-1:0]     cdb_data,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [CNT_W-1:0]      pending_count,
    output logic                  all_idle,
    output logic                  tag_conflict
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [NUM_REGS-1:0][TAG_W-1:0]  qi_q, qi_d;
    logic                            conflict_q, conflict_d;

    cdb_t     cdb;
    operand_t op_a;
    operand_t op_b;

    assign cdb.valid = cdb_valid;
    assign cdb.tag   = cdb_tag;
    assign cdb.data  = cdb_data;

    cdb_src_lookup u_lookup_a (
        .idx_i     (src_a_idx),
        .busy_i    (busy_q),
        .qi_i      (qi_q),
        .regs_i    (regs_q),
        .cdb_i     (cdb),
        .operand_o (op_a)
    );

    cdb_src_lookup u_lookup_b (
        .idx_i     (src_b_idx),
        .busy_i    (busy_q),
        .qi_i      (qi_q),
        .regs_i    (regs_q),
        .cdb_i     (cdb),
        .operand_o (op_b)
    );

    assign src_a_ready = op_a.ready;
    assign src_a_value = op_a.value;
    assign src_a_tag   = op_a.tag;
    assign src_b_ready = op_b.ready;
    assign src_b_value = op_b.value;
    assign src_b_tag   = op_b.tag;

    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        qi_d       = qi_q;
        conflict_d = conflict_q;

        for (int r = 0; r < NUM_REGS; r++) begin
            if (cdb_valid && busy_q[r] && (qi_q[r] == cdb_tag)) begin
                regs_d[r] = cdb_data;
                busy_d[r] = 1'b0;
            end
        end

        // A live owner of issue_tag survives this edge unless the CDB retires that tag now.
        if (issue_valid && !(cdb_valid && (cdb_tag == issue_tag))) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (busy_q[r] && (qi_q[r] == issue_tag)) begin
                    conflict_d = 1'b1;
                end
            end
        end

        // Applied after writeback so a same-cycle rename keeps the register busy.
        if (issue_valid) begin
            busy_d[issue_rd] = 1'b1;
            qi_d[issue_rd]   = issue_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q     <= '0;
            busy_q     <= '0;
            qi_q       <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            qi_q       <= qi_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy_mask     = busy_q;
    assign pending_count = count_ones(busy_q);
    assign all_idle      = (busy_q == '0);
    assign tag_conflict  = conflict_q;

endmodule

// File: tb/tb_cdb_register_writeback.sv
// tb/tb_cdb_register_writeback.sv - randomized and directed checks of cdb_register_writeback
module tb_cdb_register_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [2:0]  issue_rd;
    logic [1:0]  issue_tag;
    logic [2:0]  src_a_idx, src_b_idx;
    logic        src_a_ready, src_b_ready;
    logic [15:0] src_a_value, src_b_value;
    logic [1:0]  src_a_tag, src_b_tag;
    logic        cdb_valid;
    logic [1:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic [7:0]  busy_mask;
    logic [3:0]  pending_count;
    logic        all_idle;
    logic        tag_conflict;

    int checks = 0;
    int errors = 0;

    int m_regs [8];
    bit m_busy [8];
    int m_qi   [8];
    bit m_conf;

    always #5 clock = ~clock;

    cdb_register_writeback dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_tag     (issue_tag),
        .src_a_idx     (src_a_idx),
        .src_b_idx     (src_b_idx),
        .src_a_ready   (src_a_ready),
        .src_b_ready   (src_b_ready),
        .src_a_value   (src_a_value),
        .src_b_value   (src_b_value),
        .src_a_tag     (src_a_tag),
        .src_b_tag     (src_b_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .busy_mask     (busy_mask),
        .pending_count (pending_count),
        .all_idle      (all_idle),
        .tag_conflict  (tag_conflict)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_tag   = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_data    = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            m_regs[r] = 0; m_busy[r] = 0; m_qi[r] = 0;
        end
        m_conf = 0;
    endtask

    task automatic expect_operand(input string port, input int idx, input bit rdy,
                                  input int val, input int tg);
        bit e_rdy; int e_val; int e_tag;
        e_rdy = 0; e_val = 0; e_tag = 0;
        if (!m_busy[idx]) begin
            e_rdy = 1; e_val = m_regs[idx];
        end else if (cdb_valid && int'(cdb_tag) == m_qi[idx]) begin
            e_rdy = 1; e_val = int'(cdb_data);
        end else begin
            e_tag = m_qi[idx];
        end
        chk({port, "_ready"}, int'(rdy), int'(e_rdy));
        chk({port, "_value"}, val, e_val);
        chk({port, "_tag"}, tg, e_tag);
    endtask

    task automatic compare_all();
        int cnt; int mask;
        cnt = 0; mask = 0;
        for (int r = 0; r < 8; r++) begin
            if (m_busy[r]) begin
                cnt++;
                mask += (1 << r);
            end
        end
        expect_operand("src_a", int'(src_a_idx), src_a_ready, int'(src_a_value), int'(src_a_tag));
        expect_operand("src_b", int'(src_b_idx), src_b_ready, int'(src_b_value), int'(src_b_tag));
        chk("busy_mask", int'(busy_mask), mask);
        chk("pending_count", int'(pending_count), cnt);
        chk("all_idle", int'(all_idle), int'(cnt == 0));
        chk("tag_conflict", int'(tag_conflict), int'(m_conf));
    endtask

    // Reference next state from the architectural rules; blocking updates in rule order.
    task automatic model_step();
        bit hit [8];
        if (reset) begin
            model_reset();
            return;
        end
        for (int r = 0; r < 8; r++)
            hit[r] = cdb_valid && m_busy[r] && m_qi[r] == int'(cdb_tag);
        if (issue_valid) begin
            for (int r = 0; r < 8; r++)
                if (m_busy[r] && m_qi[r] == int'(issue_tag) &&
                    !(cdb_valid && cdb_tag == issue_tag))
                    m_conf = 1;
        end
        for (int r = 0; r < 8; r++) begin
            if (hit[r]) begin
                m_regs[r] = int'(cdb_data);
                m_busy[r] = 0;
            end
        end
        if (issue_valid) begin
            m_busy[issue_rd] = 1;
            m_qi[issue_rd]   = int'(issue_tag);
        end
    endtask

    // Called just after a rising edge: compares at the falling edge, then advances the model.
    task automatic cycle();
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic issue(input int rd, input int tg);
        issue_valid = 1'b1; issue_rd = rd[2:0]; issue_tag = tg[1:0];
    endtask

    task automatic bcast(input int tg, input int data);
        cdb_valid = 1'b1; cdb_tag = tg[1:0]; cdb_data = data[15:0];
    endtask

    initial begin
        idle();
        reset = 1'b1;
        src_a_idx = 3'd0;
        src_b_idx = 3'd0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;

        // 1: reset state
        idle(); src_a_idx = 3'd3; src_b_idx = 3'd7;
        #1;
        chk("t1_ready", int'(src_a_ready), 1);
        chk("t1_value", int'(src_a_value), 0);
        chk("t1_busy_mask", int'(busy_mask), 0);
        chk("t1_all_idle", int'(all_idle), 1);
        cycle();

        // 2: rename then writeback with bypass
        issue(2, 1); cycle();
        idle(); src_a_idx = 3'd2; #1;
        chk("t2_pending_ready", int'(src_a_ready), 0);
        chk("t2_pending_tag", int'(src_a_tag), 1);
        chk("t2_pending_count", int'(pending_count), 1);
        cycle();
        bcast(1, 16'h00AB); #1;
        chk("t2_bypass_ready", int'(src_a_ready), 1);
        chk("t2_bypass_value", int'(src_a_value), 16'h00AB);
        cycle();
        idle(); #1;
        chk("t2_busy_mask", int'(busy_mask), 0);
        chk("t2_reg_value", int'(src_a_value), 16'h00AB);
        cycle();

        // 3: WAW rename, stale broadcast ignored
        issue(4, 0); cycle();
        issue(4, 3); cycle();
        idle(); bcast(0, 16'h1111); src_a_idx = 3'd4; #1;
        chk("t3_stale_ready", int'(src_a_ready), 0);
        chk("t3_stale_tag", int'(src_a_tag), 3);
        cycle();
        idle(); #1;
        chk("t3_still_busy", int'(busy_mask), 8'h10);
        chk("t3_old_value", int'(src_a_value), 0);
        cycle();
        bcast(3, 16'h2222); cycle();
        idle(); #1;
        chk("t3_final_value", int'(src_a_value), 16'h2222);
        chk("t3_final_ready", int'(src_a_ready), 1);
        cycle();

        // 4: re-issue with the tag being broadcast this cycle
        issue(5, 2); cycle();
        issue(5, 2); bcast(2, 16'h0F0F); src_a_idx = 3'd5; #1;
        chk("t4_bypass_value", int'(src_a_value), 16'h0F0F);
        chk("t4_bypass_ready", int'(src_a_ready), 1);
        cycle();
        idle(); #1;
        chk("t4_busy_mask", int'(busy_mask), 8'h20);
        chk("t4_tag", int'(src_a_tag), 2);
        chk("t4_no_conflict", int'(tag_conflict), 0);
        cycle();
        bcast(2, 16'h0F0F); cycle();
        idle(); #1;
        chk("t4_reg_value", int'(src_a_value), 16'h0F0F);
        cycle();

        // 5: duplicate live tag sets the sticky conflict
        issue(1, 1); cycle();
        issue(6, 1); cycle();
        idle(); #1;
        chk("t5_conflict", int'(tag_conflict), 1);
        chk("t5_busy_mask", int'(busy_mask), 8'h42);
        cycle();
        bcast(1, 16'h3333); cycle();
        idle(); src_a_idx = 3'd6; #1;
        chk("t5_cleared", int'(busy_mask), 0);
        chk("t5_sticky", int'(tag_conflict), 1);
        chk("t5_value6", int'(src_a_value), 16'h3333);
        cycle();

        // 6: reset wins over issue and CDB
        issue(0, 0); cycle();
        issue(7, 3); cycle();
        reset = 1'b1; issue(3, 2); bcast(0, 16'h5555); cycle();
        idle(); src_a_idx = 3'd0; #1;
        chk("t6_busy_mask", int'(busy_mask), 0);
        chk("t6_pending", int'(pending_count), 0);
        chk("t6_value", int'(src_a_value), 0);
        chk("t6_conflict", int'(tag_conflict), 0);
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 3'($urandom_range(0, 7));
            issue_tag   = 2'($urandom_range(0, 3));
            cdb_valid   = ($urandom_range(0, 1) == 0);
            cdb_tag     = 2'($urandom_range(0, 3));
            cdb_data    = 16'($urandom);
            src_a_idx   = 3'($urandom_range(0, 7));
            src_b_idx   = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_register_writeback.md
Name: cdb_register_writeback

Overview:
- Receiving end of the Common Data Bus (CDB) broadcast: holds the architectural register file plus the register-status (Qi) table of the Tomasulo core.
- Issue stage renames a destination register to a reservation-station tag; a CDB broadcast carrying that tag writes the value back and clears the rename.
- Provides two source-operand lookup ports to the reservation station, with a same-cycle CDB bypass, so operands are either a value or a pending tag.

Parameters:
- NUM_REGS, 8, number of architectural registers (register index width = clog2(NUM_REGS) = 3).
- DATA_W, 16, register and CDB data width.
- TAG_W, 2, reservation-station tag width; matches the RS position field.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- issue_valid  in  1  rename request this cycle.
- issue_rd  in  3  destination register being renamed.
- issue_tag  in  TAG_W  RS tag that will produce issue_rd.
- src_a_idx, src_b_idx  in  3 each  source register indices for lookup.
- src_a_ready, src_b_ready  out  1 each  1 means operand value is valid.
- src_a_value, src_b_value  out  DATA_W each  operand value, 0 when not ready.
- src_a_tag, src_b_tag  out  TAG_W each  producing tag when not ready, 0 when ready.
- cdb_valid  in  1  broadcast present.
- cdb_tag  in  TAG_W  tag of the producing RS.
- cdb_data  in  DATA_W  result value.
- busy_mask  out  NUM_REGS  per-register busy flags (registered).
- pending_count  out  clog2(NUM_REGS)+1  number of busy registers.
- all_idle  out  1  pending_count == 0.
- tag_conflict  out  1  sticky error flag.

Behaviour:
- State: regs[NUM_REGS] (DATA_W), busy[NUM_REGS], qi[NUM_REGS] (TAG_W), tag_conflict.
- Reset (synchronous): all regs = 0, busy = 0, qi = 0, tag_conflict = 0, pending_count = 0, all_idle = 1. A reset asserted mid-operation overrides issue and CDB in that cycle.
- CDB writeback, registered with 1-cycle latency: for every r with busy[r] && qi[r] == cdb_tag while cdb_valid is high, set regs[r] = cdb_data and clear busy[r].
- A broadcast that matches no busy register is legal (result already overwritten by a later rename, or a store result): no state change.
- Issue, registered: busy[issue_rd] = 1 and qi[issue_rd] = issue_tag.
- Simultaneous issue and CDB match on the same register: regs[r] takes cdb_data, and busy/qi take the new issue values. Issue wins the rename.
- Simultaneous issue with issue_tag == cdb_tag: the broadcast clears only the old owners. The newly renamed register stays busy with that tag.
- Lookup is combinational, evaluated on pre-edge state:
  - if !busy[idx]: ready = 1, value = regs[idx].
  - else if cdb_valid && cdb_tag == qi[idx]: ready = 1, value = cdb_data (bypass).
  - else: ready = 0, value = 0, tag = qi[idx].
- An issue in the same cycle does NOT affect that cycle's lookups, so an instruction reads its sources before renaming its own destination.
- pending_count and busy_mask reflect registered state and update one cycle after an issue or writeback.
- tag_conflict is set when issue_valid is high and some register r has busy[r] && qi[r] == issue_tag, and that r is not cleared by a same-cycle cdb_valid with cdb_tag == issue_tag. The flag stays set until reset. The issue is still performed.
- No back-pressure: the block always accepts issue and CDB every cycle.

Decomposition:
- Shared package (tomasulo_pkg):
  - DATA_W, TAG_W, NUM_REGS, REG_IDX_W constants.
  - cdb_t struct {valid, tag, data}.
  - operand_t struct {ready, value, tag}; also consumed by the reservation station.
- One sub-module, cdb_src_lookup: a single lookup port including the bypass logic, instantiated twice (ports A and B).

Test Plan:
1. Reset, then lookup src_a_idx=3 -> ready=1, value=0. busy_mask=0, all_idle=1.
2. Issue rd=2 tag=1. Next cycle lookup 2 -> ready=0, tag=1, pending_count=1. Then cdb_valid tag=1 data=0x00AB: same cycle lookup 2 gives ready=1, value=0x00AB via bypass; next cycle busy_mask[2]=0 and regs[2]=0x00AB.
3. Issue rd=4 tag=0, then issue rd=4 tag=3 (WAW). CDB tag=0 data=0x1111 -> reg 4 stays busy with tag 3, value unchanged. CDB tag=3 data=0x2222 -> reg 4 = 0x2222, not busy.
4. Reg 5 busy with tag 2. In the same cycle issue rd=5 tag=2 and CDB tag=2 data=0x0F0F -> regs[5]=0x0F0F, busy[5]=1, qi[5]=2, tag_conflict stays 0. Same-cycle lookup of 5 returns 0x0F0F ready.
5. Reg 1 busy with tag 1, no CDB. Issue rd=6 tag=1 -> tag_conflict=1 from the next cycle and stays 1 until reset. Both regs 1 and 6 are busy with tag 1; then CDB tag=1 clears both.
6. Regs 0 and 7 busy. Assert reset in the same cycle as issue rd=3 and CDB for 0's tag -> next cycle all busy=0, regs=0, pending_count=0.
